// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
// Holds the fetch FSM state encoding and the buffered {addr, data} entry.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 2;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched {address, instruction} entries for decode.
// Ports: clock/reset, clear (highest priority), push/push_entry, pop,
//        count (occupancy), head (entry at the read pointer).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output entry_t        head
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    // DEPTH is a power of two, so pointer wrap is plain truncation.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: latches pc_addr, runs a req/ack memory read and
// buffers {addr, data} for decode; flush discards buffered and in-flight
// fetches. Ports: clock, reset (sync, active-high), pc_addr, flush,
// addr_taken, mem_req/mem_addr/mem_ack/mem_rdata, instr_valid/ready/
// data/addr/link, fetch_fault. Optional macro FETCH_TIMEOUT_EN adds a
// WAIT/DROP watchdog that raises a sticky fetch_fault and halts fetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    output logic              addr_taken,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [ADDR_W-1:0] instr_link,
    output logic              fetch_fault
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              addr_taken_q, addr_taken_d;

    logic              push;
    entry_t            push_entry;
    entry_t            head;
    logic [CW-1:0]     count;
    logic              halt;
    logic              tmo_hit;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        addr_taken_d = 1'b0;
        push         = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Room is checked against the current count so a
                // granted request can never overflow the FIFO.
                if (!flush && !halt && (count < CW'(DEPTH))) begin
                    mem_addr_d   = pc_addr;
                    mem_req_d    = 1'b1;
                    addr_taken_d = 1'b1;
                    state_d      = WAIT;
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    push      = !flush;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        if (tmo_hit) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            addr_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            addr_taken_q <= addr_taken_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          fault_q, fault_d;

    // An ack on the final allowed cycle still completes normally.
    assign tmo_hit = (state_q != IDLE) && !mem_ack
                   && (tmo_q == TW'(TIMEOUT - 1));
    assign halt    = fault_q;

    // One count spans the whole transaction, WAIT through DROP.
    always_comb begin
        fault_d = fault_q | tmo_hit;
        if ((state_q != IDLE) && (state_d != IDLE)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign tmo_hit        = 1'b0;
    assign halt           = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

    assign push_entry = '{addr: mem_addr_q, data: mem_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (instr_ready),
        .count      (count),
        .head       (head)
    );

    assign addr_taken  = addr_taken_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count != '0);
    assign instr_data  = head.data;
    assign instr_addr  = head.addr;
    assign instr_link  = head.addr + ADDR_W'(1);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level model with a
// per-cycle compare, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam int TMO   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_addr = '0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_ready = 1'b0;

    logic        addr_taken;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic [31:0] instr_link;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    instr_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .flush       (flush),
        .addr_taken  (addr_taken),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .instr_link  (instr_link),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level model: one outstanding read, a list of entries.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_out;
    bit          m_drop;
    bit          m_taken;
    bit          m_fault;
    logic [31:0] m_addr;
    int          m_tmo;

    always @(posedge clock) begin : model
        bit   do_push;
        bit   can_pop;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_out   = 0;
            m_drop  = 0;
            m_taken = 0;
            m_fault = 0;
            m_addr  = '0;
            m_tmo   = 0;
        end else begin
            do_push = 0;
            e.a     = '0;
            e.d     = '0;
            m_taken = 0;
            can_pop = instr_ready && (mq.size() > 0);
            if (!m_out) begin
                if (!flush && mq.size() < DEPTH && !m_fault) begin
                    m_out   = 1;
                    m_drop  = 0;
                    m_addr  = pc_addr;
                    m_taken = 1;
                    m_tmo   = 0;
                end
            end else if (mem_ack) begin
                if (!flush && !m_drop) begin
                    do_push = 1;
                    e.a     = m_addr;
                    e.d     = mem_rdata;
                end
                m_out = 0;
            end else begin
                if (flush) m_drop = 1;
`ifdef FETCH_TIMEOUT_EN
                m_tmo++;
                if (m_tmo >= TMO) begin
                    m_fault = 1;
                    m_out   = 0;
                end
`endif
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (can_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(e);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_req", mem_req, m_out);
            check("mem_addr", mem_addr, m_addr);
            check("addr_taken", addr_taken, m_taken);
            check("fetch_fault", fetch_fault, m_fault);
            check("instr_valid", instr_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("instr_addr", instr_addr, mq[0].a);
                check("instr_data", instr_data, mq[0].d);
                check("instr_link", instr_link, mq[0].a + 32'd1);
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        check("rst_mem_req", mem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_taken", addr_taken, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_mem_addr", mem_addr, 0);

        // Basic fetch, ack on the 3rd WAIT cycle
        reset   = 1'b0;
        pc_addr = 32'h10;
        step();
        check("t1_taken", addr_taken, 1);
        check("t1_addr", mem_addr, 32'h10);
        pc_addr = 32'h11;
        step();
        check("t1_taken_once", addr_taken, 0);
        check("t1_addr_hold", mem_addr, 32'h10);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hE3A00001;
        step();
        mem_ack = 1'b0;
        check("t1_valid", instr_valid, 1);
        check("t1_iaddr", instr_addr, 32'h10);
        check("t1_idata", instr_data, 32'hE3A00001);
        check("t1_link", instr_link, 32'h11);

        // Fill the FIFO, then free one slot
        do_reset();
        pc_addr = 32'h20;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hA0;
        step();
        mem_ack = 1'b0;
        pc_addr = 32'h21;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hA1;
        step();
        mem_ack = 1'b0;
        pc_addr = 32'h22;
        step();
        step();
        check("t2_full_noreq", mem_req, 0);
        check("t2_head0", instr_addr, 32'h20);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t2_head1", instr_addr, 32'h21);
        check("t2_head1_data", instr_data, 32'hA1);
        step();
        check("t2_reissue", mem_req, 1);
        check("t2_reissue_addr", mem_addr, 32'h22);

        // Flush in WAIT goes through DROP
        do_reset();
        pc_addr = 32'h30;
        step();
        flush = 1'b1;
        step();
        flush   = 1'b0;
        pc_addr = 32'h40;
        check("t3_drop_req", mem_req, 1);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        check("t3_discard", instr_valid, 0);
        check("t3_idle", mem_req, 0);
        step();
        check("t3_new_req", mem_req, 1);
        check("t3_new_addr", mem_addr, 32'h40);

        // Flush and ack together with one entry buffered
        do_reset();
        pc_addr = 32'h50;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111;
        step();
        mem_ack = 1'b0;
        pc_addr = 32'h51;
        step();
        check("t4_buffered", instr_valid, 1);
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222;
        step();
        flush   = 1'b0;
        mem_ack = 1'b0;
        check("t4_empty", instr_valid, 0);
        check("t4_noreq", mem_req, 0);
        step();
        check("t4_idle_issue", mem_req, 1);
        check("t4_issue_addr", mem_addr, 32'h51);

        // Reset mid-WAIT, then a late ack seen in IDLE
        do_reset();
        pc_addr = 32'h60;
        step();
        reset = 1'b1;
        step();
        check("t5_req_cleared", mem_req, 0);
        check("t5_valid_cleared", instr_valid, 0);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55;
        step();
        mem_ack = 1'b0;
        check("t5_late_ack", instr_valid, 0);
        check("t5_new_req", mem_req, 1);
        step();
        step();
        check("t5_still_empty", instr_valid, 0);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: no ack for TMO cycles
        do_reset();
        pc_addr = 32'h70;
        step();
        repeat (TMO - 1) step();
        check("t6_pre_fault", fetch_fault, 0);
        check("t6_pre_req", mem_req, 1);
        step();
        check("t6_fault", fetch_fault, 1);
        check("t6_req_off", mem_req, 0);
        pc_addr = 32'h71;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_halt_taken", addr_taken, 0);
            check("t6_halt_req", mem_req, 0);
        end
        do_reset();
        check("t6_fault_clr", fetch_fault, 0);
`endif

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
